vector_register_file_mp: RTL and testbench
==========================================

Name: vector_register_file_mp

Overview:
Multi-port vector register file for the vector lane, generalising the single-write, three-read register file.
- Configurable numbers of read and write ports.
- Element-granular write masking.
- Optional write-to-read bypass.
- Sequential clear of all registers after reset, with a completion flag.
- Exposes v0 as the mask register and flags same-cycle write conflicts. Sits between lane issue/operand-collection logic and the execution/load-writeback paths.

Parameters:
- VREG_BITS, 64, bits per vector register.
- NUMBER_OF_REGISTERS, 32, register count; AW = $clog2(NUMBER_OF_REGISTERS).
- ELEM_BITS, 8, write-mask granularity in bits. VREG_BITS must be a multiple of ELEM_BITS; NE = VREG_BITS/ELEM_BITS.
- READ_PORTS, 3, number of read ports (>=1).
- WRITE_PORTS, 2, number of write ports (>=1). Port 0 is ALU writeback, port 1 is load writeback.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return the pre-write value.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rd_en  in  READ_PORTS  per-port read enable
- rd_addr  in  READ_PORTS*AW  read addresses; port i occupies slice [i*AW +: AW]
- rd_data  out  READ_PORTS*VREG_BITS  registered read data, same slicing
- wr_en  in  WRITE_PORTS  per-port write enable
- wr_addr  in  WRITE_PORTS*AW  write addresses
- wr_data  in  WRITE_PORTS*VREG_BITS  write data
- wr_elem_mask  in  WRITE_PORTS*NE  per-element write enables
- mask_register  out  VREG_BITS  current contents of register 0
- init_done  out  1  high once the post-reset clear completes
- wr_conflict  out  1  registered pulse flagging an overlapping same-address write

Behaviour:
- Reset (synchronous, active-high, one clock):
  - FSM goes to CLEAR; clear counter = 0.
  - All rd_data = 0, init_done = 0, wr_conflict = 0.
- CLEAR state:
  - Each cycle writes register[counter] = 0 and increments the counter.
  - After writing register NUMBER_OF_REGISTERS-1, the FSM goes to READY.
  - init_done rises on the cycle after the last clear write, i.e. exactly NUMBER_OF_REGISTERS cycles after rst deasserts.
  - During CLEAR, all wr_en and rd_en are ignored and rd_data is held at 0.
  - rst asserted mid-CLEAR restarts the counter at 0.
- READY state:
  - Stays in READY until rst; init_done stays 1.
  - rst in READY re-enters CLEAR.
- Write (READY only):
  - For each port p with wr_en[p]=1: element e of register wr_addr[p] is updated from wr_data[p] where wr_elem_mask[p][e]=1. Unmasked elements retain their value.
  - Writes take effect at the clock edge.
- Multiple ports, same address, same cycle:
  - Disjoint masks merge.
  - Elements enabled on more than one port take the highest-index port's data.
  - If any element overlaps, wr_conflict = 1 on the following cycle for one cycle; otherwise 0.
  - Different addresses never conflict.
- Read (READY only):
  - Latency 1. rd_data[i] is registered from register rd_addr[i] when rd_en[i]=1; otherwise it holds its previous value.
  - Any number of read ports may read the same address.
  - BYPASS=1: if rd_addr[i] matches one or more enabled write addresses in the same cycle, rd_data[i] gets the post-write merged value (same priority rule as writes).
  - BYPASS=0: rd_data[i] gets the pre-write value.
- mask_register:
  - Combinational view of array register 0, reflecting writes from the previous edge (no bypass).
  - Reads 0 during and after CLEAR until written.
- Address range: addresses >= NUMBER_OF_REGISTERS (non-power-of-two counts) are ignored for writes and return 0 on reads.
- Counter wrap: the clear counter is AW+1 bits wide so the terminal count is unambiguous for power-of-two register counts.

Test Plan:
- Reset/clear: assert rst for 1 cycle, default params.
  - init_done = 0 for 32 cycles, then 1.
  - Writes issued during CLEAR are dropped: reading v5 afterwards returns 0.
  - rst at cycle 10 of CLEAR restarts the count: init_done rises 32 cycles after the second rst.
- Masked write: port0 writes v3 = 0x1111_2222_3333_4444 with mask 8'hFF, then 0xAAAA_AAAA_AAAA_AAAA with mask 8'h0F; read v3 -> 0x1111_2222_AAAA_AAAA after 1 cycle.
- Same-address writes:
  - port0 v7 = 0x00..01 mask 8'hF0 and port1 v7 = 0xFF..FF mask 8'h0F -> v7 = 0x0000_0000_FFFF_FFFF, wr_conflict = 0.
  - Repeat with both masks 8'hFF -> v7 = 0xFF..FF, wr_conflict = 1 for exactly one cycle.
- Bypass:
  - BYPASS=1: same cycle write v9 = 0xDEAD_BEEF_0000_0001 and read v9 on all 3 ports -> all rd_data = 0xDEAD_BEEF_0000_0001 next cycle.
  - BYPASS=0 build: same stimulus returns the old value (0).
- Hold/mask:
  - rd_en = 0 keeps rd_data stable while the array changes.
  - Write v0 = 0x0F -> mask_register = 0x0F the cycle after the write edge.
- Parameter sweep: READ_PORTS=4, WRITE_PORTS=3, ELEM_BITS=16, VREG_BITS=128, NUMBER_OF_REGISTERS=24.
  - Clear takes 24 cycles.
  - Port 2 wins overlapping writes.
  - Reading address 30 returns 0.

Source files
------------

// File: rtl/vector_register_file_mp.sv
// Multi-port vector register file with element-masked writes, optional
// write-to-read forwarding, post-reset sequential clear and conflict flag.
module vector_register_file_mp #(
  parameter  int VREG_BITS           = 64,
  parameter  int NUMBER_OF_REGISTERS = 32,
  parameter  int ELEM_BITS           = 8,
  parameter  int READ_PORTS          = 3,
  parameter  int WRITE_PORTS         = 2,
  parameter  int BYPASS              = 1,
  localparam int AW                  = $clog2(NUMBER_OF_REGISTERS),
  localparam int NE                  = VREG_BITS / ELEM_BITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [READ_PORTS-1:0]             rd_en,
  input  logic [READ_PORTS*AW-1:0]          rd_addr,
  output logic [READ_PORTS*VREG_BITS-1:0]   rd_data,
  input  logic [WRITE_PORTS-1:0]            wr_en,
  input  logic [WRITE_PORTS*AW-1:0]         wr_addr,
  input  logic [WRITE_PORTS*VREG_BITS-1:0]  wr_data,
  input  logic [WRITE_PORTS*NE-1:0]         wr_elem_mask,
  output logic [VREG_BITS-1:0]              mask_register,
  output logic                              init_done,
  output logic                              wr_conflict
);

  typedef enum logic {CLEAR, READY} state_t;

  // Counter is one bit wider than an address so the last index is unambiguous.
  localparam logic [AW:0] LAST = (AW + 1)'(NUMBER_OF_REGISTERS - 1);

  state_t                 state, state_next;
  logic [AW:0]            clear_cnt, clear_cnt_next;
  logic [VREG_BITS-1:0]   regs    [NUMBER_OF_REGISTERS];
  logic [VREG_BITS-1:0]   rd_next [READ_PORTS];
  logic [VREG_BITS-1:0]   rd_reg  [READ_PORTS];
  logic [WRITE_PORTS-1:0] wr_ok;
  logic                   ready;
  logic                   conflict_next;

  // Addresses past the last register (non-power-of-two counts) are inert.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return int'(a) < NUMBER_OF_REGISTERS;
  endfunction

  assign ready         = (state == READY);
  assign init_done     = ready;
  assign mask_register = regs[0];

  // A write port is effective only in READY and for an existing register.
  generate
    for (genvar gi = 0; gi < WRITE_PORTS; gi++) begin : g_wr_ok
      assign wr_ok[gi] = ready && wr_en[gi] && addr_ok(wr_addr[gi*AW +: AW]);
    end
    for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd_out
      assign rd_data[gi*VREG_BITS +: VREG_BITS] = rd_reg[gi];
    end
  endgenerate

  // State and clear-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clear_cnt <= '0;
    end else begin
      state     <= state_next;
      clear_cnt <= clear_cnt_next;
    end
  end

  // Walk the counter through every register, then settle in READY.
  always_comb begin
    state_next     = state;
    clear_cnt_next = clear_cnt;
    case (state)
      CLEAR: begin
        clear_cnt_next = clear_cnt + 1'b1;
        if (clear_cnt == LAST) state_next = READY;
      end
      READY: state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  // Register array: zero one entry per cycle while clearing, otherwise apply
  // masked writes in port order so the highest-index port wins overlaps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clear_cnt[AW-1:0]] <= '0;
      end else begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          for (int e = 0; e < NE; e++) begin
            if (wr_ok[p] && wr_elem_mask[p*NE + e])
              regs[wr_addr[p*AW +: AW]][e*ELEM_BITS +: ELEM_BITS] <=
                wr_data[p*VREG_BITS + e*ELEM_BITS +: ELEM_BITS];
          end
        end
      end
    end
  end

  // Per-read-port value to capture, including same-cycle write forwarding.
  always_comb begin
    for (int i = 0; i < READ_PORTS; i++) begin
      rd_next[i] = '0;
      if (addr_ok(rd_addr[i*AW +: AW])) begin
        rd_next[i] = regs[rd_addr[i*AW +: AW]];
        if (BYPASS != 0) begin
          for (int p = 0; p < WRITE_PORTS; p++) begin
            for (int e = 0; e < NE; e++) begin
              if (wr_ok[p] && wr_elem_mask[p*NE + e] &&
                  wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW])
                rd_next[i][e*ELEM_BITS +: ELEM_BITS] =
                  wr_data[p*VREG_BITS + e*ELEM_BITS +: ELEM_BITS];
            end
          end
        end
      end
    end
  end

  // Read data registers: load on enable in READY, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_PORTS; i++) rd_reg[i] <= '0;
    end else if (ready) begin
      for (int i = 0; i < READ_PORTS; i++) begin
        if (rd_en[i]) rd_reg[i] <= rd_next[i];
      end
    end
  end

  // Any pair of ports hitting the same register with a shared element.
  always_comb begin
    conflict_next = 1'b0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      for (int q = p + 1; q < WRITE_PORTS; q++) begin
        if (wr_ok[p] && wr_ok[q] &&
            wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW] &&
            |(wr_elem_mask[p*NE +: NE] & wr_elem_mask[q*NE +: NE]))
          conflict_next = 1'b1;
      end
    end
  end

  // One-cycle conflict pulse following the offending edge.
  always_ff @(posedge clk) begin
    if (rst) wr_conflict <= 1'b0;
    else     wr_conflict <= conflict_next;
  end

endmodule

// File: tb/tb_vector_register_file_mp.sv
// Directed scoreboard bench: default build, a no-forwarding build sharing its
// inputs, and a wide/odd-sized build.
module tb_vector_register_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter stimulus (shared by the forwarding and non-forwarding builds)
  logic         rst;
  logic [2:0]   rd_en;
  logic [14:0]  rd_addr;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_elem_mask;
  logic [191:0] rd_data, rd_data_b;
  logic [63:0]  mask_register, mask_register_b;
  logic         init_done, init_done_b, wr_conflict, wr_conflict_b;

  // Sweep build stimulus
  logic         s_rst;
  logic [3:0]   s_rd_en;
  logic [19:0]  s_rd_addr;
  logic [511:0] s_rd_data;
  logic [2:0]   s_wr_en;
  logic [14:0]  s_wr_addr;
  logic [383:0] s_wr_data;
  logic [23:0]  s_wr_elem_mask;
  logic [127:0] s_mask_register;
  logic         s_init_done, s_wr_conflict;

  vector_register_file_mp dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_elem_mask(wr_elem_mask),
    .mask_register(mask_register), .init_done(init_done), .wr_conflict(wr_conflict));

  vector_register_file_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_elem_mask(wr_elem_mask),
    .mask_register(mask_register_b), .init_done(init_done_b), .wr_conflict(wr_conflict_b));

  vector_register_file_mp #(.VREG_BITS(128), .NUMBER_OF_REGISTERS(24), .ELEM_BITS(16),
                            .READ_PORTS(4), .WRITE_PORTS(3)) dut_s (
    .clk(clk), .rst(s_rst), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_elem_mask(s_wr_elem_mask),
    .mask_register(s_mask_register), .init_done(s_init_done), .wr_conflict(s_wr_conflict));

  logic [127:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs);
    logic [127:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
    $display("check %-16s observed %h expected %h", tag, obs, e);
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [63:0] d, input logic [7:0] m);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*64 +: 64] = d;
    wr_elem_mask[p*8 +: 8] = m;
  endtask

  task automatic rd(input int i, input logic [4:0] a);
    rd_en[i] = 1'b1;
    rd_addr[i*5 +: 5] = a;
  endtask

  task automatic swr(input int p, input logic [4:0] a, input logic [127:0] d, input logic [7:0] m);
    s_wr_en[p] = 1'b1;
    s_wr_addr[p*5 +: 5] = a;
    s_wr_data[p*128 +: 128] = d;
    s_wr_elem_mask[p*8 +: 8] = m;
  endtask

  task automatic srd(input int i, input logic [4:0] a);
    s_rd_en[i] = 1'b1;
    s_rd_addr[i*5 +: 5] = a;
  endtask

  task automatic idle();
    wr_en = '0; rd_en = '0; s_wr_en = '0; s_rd_en = '0;
  endtask

  initial begin
    int n;
    rst = 1'b1; s_rst = 1'b1;
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_elem_mask = '0;
    s_rd_en = '0; s_rd_addr = '0; s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0;
    s_wr_elem_mask = '0;

    // Reset state
    exp_q.push_back(128'd0); exp_q.push_back(128'd0); exp_q.push_back(128'd0);
    step();
    rst = 1'b0;
    chk("rst_rd_data", 128'(rd_data[63:0]));
    chk("rst_init_done", 128'(init_done));
    chk("rst_wr_conflict", 128'(wr_conflict));

    // Writes/reads during the clear are ignored; rst at cycle 10 restarts it
    wr(0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    rd(0, 5'd5);
    exp_q.push_back(128'd0);
    for (int k = 0; k < 9; k++) step();
    chk("clear_init_done", 128'(init_done));
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.push_back(128'd32);
    n = 0;
    while (!init_done && n < 100) begin
      step();
      n++;
    end
    chk("clear_cycles", 128'(n));
    idle();
    exp_q.push_back(128'd0); exp_q.push_back(128'd0);
    chk("clear_rd_held", 128'(rd_data[63:0]));
    chk("mask_after_clr", 128'(mask_register));
    rd(0, 5'd5);
    exp_q.push_back(128'd0);
    step();
    idle();
    chk("v5_dropped", 128'(rd_data[63:0]));

    // Masked write
    wr(0, 5'd3, 64'h1111_2222_3333_4444, 8'hFF);
    step();
    wr(0, 5'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    step();
    idle();
    rd(1, 5'd3);
    exp_q.push_back(128'h1111_2222_AAAA_AAAA);
    step();
    idle();
    chk("masked_write", 128'(rd_data[127:64]));

    // Same address, disjoint masks
    wr(0, 5'd7, 64'h0000_0000_0000_0001, 8'hF0);
    wr(1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    exp_q.push_back(128'd0);
    step();
    idle();
    chk("merge_no_conf", 128'(wr_conflict));
    rd(0, 5'd7);
    exp_q.push_back(128'h0000_0000_FFFF_FFFF);
    step();
    idle();
    chk("merge_data", 128'(rd_data[63:0]));

    // Same address, overlapping masks: port 1 wins, one-cycle conflict pulse
    wr(0, 5'd7, 64'h0000_0000_0000_0001, 8'hFF);
    wr(1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    exp_q.push_back(128'd1);
    step();
    idle();
    chk("overlap_conf", 128'(wr_conflict));
    rd(0, 5'd7);
    exp_q.push_back(128'd0);
    exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF);
    exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF);
    step();
    idle();
    chk("conf_pulse_end", 128'(wr_conflict));
    chk("overlap_data", 128'(rd_data[63:0]));
    chk("overlap_data_b", 128'(rd_data_b[63:0]));

    // Same-cycle write and read of v9
    wr(0, 5'd9, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    rd(0, 5'd9); rd(1, 5'd9); rd(2, 5'd9);
    for (int i = 0; i < 3; i++) exp_q.push_back(128'hDEAD_BEEF_0000_0001);
    exp_q.push_back(128'd0);
    step();
    idle();
    for (int i = 0; i < 3; i++) chk("bypass_port", 128'(rd_data[i*64 +: 64]));
    chk("no_bypass_old", 128'(rd_data_b[63:0]));

    // Hold while disabled, then confirm the array did change
    wr(0, 5'd9, 64'h5555_5555_5555_5555, 8'hFF);
    exp_q.push_back(128'hDEAD_BEEF_0000_0001);
    exp_q.push_back(128'd0);
    step();
    idle();
    chk("hold_a", 128'(rd_data[63:0]));
    chk("hold_b", 128'(rd_data_b[63:0]));
    rd(1, 5'd9);
    exp_q.push_back(128'h5555_5555_5555_5555);
    step();
    idle();
    chk("v9_updated", 128'(rd_data[127:64]));

    // Mask register view of v0
    wr(0, 5'd0, 64'h0F, 8'hFF);
    exp_q.push_back(128'h0F); exp_q.push_back(128'h0F);
    step();
    idle();
    chk("mask_reg", 128'(mask_register));
    chk("mask_reg_b", 128'(mask_register_b));

    // Sweep build: 24-entry clear
    s_rst = 1'b0;
    exp_q.push_back(128'd24);
    n = 0;
    while (!s_init_done && n < 100) begin
      step();
      n++;
    end
    chk("s_clear_cycles", 128'(n));

    // Three ports on v4 with nested masks: port 2 beats 1 beats 0
    swr(0, 5'd4, {8{16'hA0A0}}, 8'hFF);
    swr(1, 5'd4, {8{16'hB1B1}}, 8'h0F);
    swr(2, 5'd4, {8{16'hC2C2}}, 8'h03);
    exp_q.push_back(128'd1);
    step();
    idle();
    chk("s_conf", 128'(s_wr_conflict));
    srd(0, 5'd4); srd(3, 5'd4);
    swr(0, 5'd30, {128{1'b1}}, 8'hFF);
    exp_q.push_back(128'd0);
    exp_q.push_back({{4{16'hA0A0}}, {2{16'hB1B1}}, {2{16'hC2C2}}});
    exp_q.push_back({{4{16'hA0A0}}, {2{16'hB1B1}}, {2{16'hC2C2}}});
    step();
    idle();
    chk("s_no_conf", 128'(s_wr_conflict));
    chk("s_prio_p0", s_rd_data[127:0]);
    chk("s_prio_p3", s_rd_data[511:384]);

    // Out-of-range address: write ignored, read (even forwarded) gives 0
    srd(0, 5'd30);
    swr(1, 5'd30, {128{1'b1}}, 8'hFF);
    exp_q.push_back(128'd0);
    step();
    idle();
    chk("s_addr30", s_rd_data[127:0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
